decode_mac_pipe: RTL

Parametrised signed multiply/accumulate pipeline for the decode datapath. It generalises the fixed two-stage signed multiplier with a configurable stage count, valid tracking, a frozen-pipeline clock enable, round-and-shift scaling, saturation into the output width, and a per-element multiply-only or dot-product mode. It sits between the coefficient/feature fetch and the decode result buffer. In accumulate mode, a sum of products leaves the block with one result per `last` element.

---
 rtl/decode_mac_pkg.sv | 44 ++++
 rtl/decode_mac_pipe_if.sv | 26 ++
 rtl/decode_mul_pipe.sv | 58 +++++
 rtl/decode_mac_pipe.sv | 128 ++++++++++++
 4 files changed

// File: rtl/decode_mac_pkg.sv
// Shared types and arithmetic helpers for the decode MAC datapath.
// All rounding and clamping is done in one wide signed type so that no intermediate value can wrap.
package decode_mac_pkg;

    localparam int MAX_W = 160;
    // Widths for the default configuration (40x33 operands, 70-bit result).
    localparam int PW    = 40 + 33;
    localparam int GW    = ((PW > 70) ? PW : 70) + 1;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic  flag;
        wide_t val;
    } sat_t;

    // Adds half an LSB before the arithmetic shift, so rounding is half toward +inf.
    function automatic wide_t round_shift(input wide_t p, input int sh);
        wide_t r;
        if (sh > 0) r = (p + (wide_t'(1) <<< (sh - 1))) >>> sh;
        else        r = p;
        return r;
    endfunction

    function automatic sat_t sat_clamp(input wide_t x, input int w);
        sat_t  r;
        wide_t mx;
        wide_t mn;
        mx = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mn = -(wide_t'(1) <<< (w - 1));
        if (x > mx) begin
            r.flag = 1'b1;
            r.val  = mx;
        end else if (x < mn) begin
            r.flag = 1'b1;
            r.val  = mn;
        end else begin
            r.flag = 1'b0;
            r.val  = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/decode_mac_pipe_if.sv
// Element stream into the MAC and the result stream out of it.
interface decode_mac_pipe_if #(
    parameter int din0_WIDTH = 40,
    parameter int din1_WIDTH = 33,
    parameter int dout_WIDTH = 70
);
    logic                         in_valid;
    logic                         mode;
    logic                         first;
    logic                         last;
    logic signed [din0_WIDTH-1:0] din0;
    logic signed [din1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic signed [dout_WIDTH-1:0] dout;
    logic                         ovf;

    modport master (
        output in_valid, mode, first, last, din0, din1,
        input  out_valid, dout, ovf
    );

    modport slave (
        input  in_valid, mode, first, last, din0, din1,
        output out_valid, dout, ovf
    );
endinterface

// File: rtl/decode_mul_pipe.sv
// NUM_STAGE-deep signed multiplier carrying a valid bit and a sideband vector.
// The product is full width; the retimable tail stages are plain delay.
module decode_mul_pipe #(
    parameter int NUM_STAGE = 2,
    parameter int A_W       = 40,
    parameter int B_W       = 33,
    parameter int SB_W      = 3,
    localparam int P_W      = A_W + B_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [SB_W-1:0]       sb_in,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic                  out_valid,
    output logic [SB_W-1:0]       sb_out,
    output logic signed [P_W-1:0] p
);

    logic [NUM_STAGE-1:0]  vld_pipe_q, vld_pipe_d;
    logic [SB_W-1:0]       sb_q   [NUM_STAGE];
    logic [SB_W-1:0]       sb_d   [NUM_STAGE];
    logic signed [P_W-1:0] prod_q [NUM_STAGE];
    logic signed [P_W-1:0] prod_d [NUM_STAGE];

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        sb_d       = sb_q;
        prod_d     = prod_q;
        if (ce) begin
            vld_pipe_d[0] = in_valid;
            sb_d[0]       = sb_in;
            prod_d[0]     = P_W'(a) * P_W'(b);
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                sb_d[i]       = sb_q[i-1];
                prod_d[i]     = prod_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) vld_pipe_q <= '0;
        else       vld_pipe_q <= vld_pipe_d;
    end

    always_ff @(posedge clk) begin
        sb_q   <= sb_d;
        prod_q <= prod_d;
    end

    assign out_valid = vld_pipe_q[NUM_STAGE-1];
    assign sb_out    = sb_q[NUM_STAGE-1];
    assign p         = prod_q[NUM_STAGE-1];

endmodule

// File: rtl/decode_mac_pipe.sv
// Signed multiply/accumulate pipeline: NUM_STAGE multiply stages followed by
// one round/saturate/accumulate stage, so the latency is NUM_STAGE+1 enabled cycles.
module decode_mac_pipe
    import decode_mac_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 40,
    parameter int din1_WIDTH = 33,
    parameter int dout_WIDTH = 70,
    parameter int SHIFT      = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    decode_mac_pipe_if.slave    bus
);

    localparam int P_W = din0_WIDTH + din1_WIDTH;
    localparam int G_W = ((P_W > dout_WIDTH) ? P_W : dout_WIDTH) + 1;

    if (NUM_STAGE < 1 || NUM_STAGE > 4 || SHIFT < 0 || SHIFT >= P_W || G_W > MAX_W || ID < 0)
    begin : g_bad_param
        $error("decode_mac_pipe: illegal parameter set");
    end

    logic                  m_vld;
    logic [2:0]            m_sb;
    logic signed [P_W-1:0] m_prod;

    decode_mul_pipe #(
        .NUM_STAGE (NUM_STAGE),
        .A_W       (din0_WIDTH),
        .B_W       (din1_WIDTH),
        .SB_W      (3)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (bus.in_valid),
        .sb_in     ({bus.mode, bus.first, bus.last}),
        .a         (bus.din0),
        .b         (bus.din1),
        .out_valid (m_vld),
        .sb_out    (m_sb),
        .p         (m_prod)
    );

    logic m_mode, m_first, m_last;
    assign {m_mode, m_first, m_last} = m_sb;

    logic signed [dout_WIDTH-1:0] acc_q, acc_d;
    logic                         sticky_q, sticky_d;
    logic signed [dout_WIDTH-1:0] dout_q, dout_d;
    logic                         ovf_q, ovf_d;
    logic                         out_valid_q, out_valid_d;

    wide_t                        s_rs;
    sat_t                         s_st;
    logic signed [dout_WIDTH-1:0] s_sat;
    wide_t                        acc_sum;
    sat_t                         a_st;
    logic signed [dout_WIDTH-1:0] acc_new;
    logic                         flag_new;

    // Scaled product and the candidate running sum, both clamped to dout_WIDTH.
    always_comb begin
        s_rs    = round_shift(wide_t'(m_prod), SHIFT);
        s_st    = sat_clamp(s_rs, dout_WIDTH);
        s_sat   = dout_WIDTH'(s_st.val);
        acc_sum = wide_t'(acc_q) + wide_t'(s_sat);
        a_st    = sat_clamp(acc_sum, dout_WIDTH);
        if (m_first) begin
            acc_new  = s_sat;
            flag_new = s_st.flag;
        end else begin
            acc_new  = dout_WIDTH'(a_st.val);
            flag_new = sticky_q | s_st.flag | a_st.flag;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = 1'b0;
            if (m_vld && !m_mode) begin
                dout_d      = s_sat;
                ovf_d       = s_st.flag;
                out_valid_d = 1'b1;
            end else if (m_vld && m_last) begin
                // Closing element emits the sum and leaves the accumulator empty.
                dout_d      = acc_new;
                ovf_d       = flag_new;
                out_valid_d = 1'b1;
                acc_d       = '0;
                sticky_d    = 1'b0;
            end else if (m_vld) begin
                acc_d    = acc_new;
                sticky_d = flag_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;

endmodule
